// File: rtl/pc_stack_pkg.sv
// Shared op codes and sizing helpers for the program counter with return-address stack.
package pc_stack_pkg;

  typedef enum logic [2:0] {
    OpHold   = 3'd0,
    OpInc    = 3'd1,
    OpLoad   = 3'd2,
    OpJrel   = 3'd3,
    OpCall   = 3'd4,
    OpRet    = 3'd5,
    OpDec    = 3'd6,
    OpClrErr = 3'd7
  } pc_op_t;

  // The stack pointer must count 0..depth inclusive.
  function automatic int unsigned sp_width(int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned addr_width(int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO: push/pop with full/empty decoded from the registered stack pointer.
module pc_ret_stack
  import pc_stack_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned SpW   = sp_width(STACK_DEPTH);
  localparam int unsigned AddrW = addr_width(STACK_DEPTH);
  localparam logic [SpW-1:0] SpMax = SpW'(STACK_DEPTH);

  logic [SpW-1:0]   sp_q, sp_d, top_idx;
  logic [WIDTH-1:0] mem_q [2**AddrW];

  assign full_o  = (sp_q == SpMax);
  assign empty_o = (sp_q == '0);
  assign top_idx = sp_q - SpW'(1);
  assign data_o  = mem_q[top_idx[AddrW-1:0]];

  always_comb begin
    sp_d = sp_q;
    if (push_i && !full_o) begin
      sp_d = sp_q + SpW'(1);
    end else if (pop_i && !empty_o) begin
      sp_d = sp_q - SpW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  // Contents are don't-care after reset, so the storage carries no reset.
  always_ff @(posedge clk) begin
    if (push_i && !full_o) begin
      mem_q[sp_q[AddrW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/pc_stack_counter.sv
// Program counter with up/down count, relative jump and call/return stack.
// Define PC_SATURATE_EN to clamp out-of-range INC/DEC/JREL instead of wrapping.
module pc_stack_counter
  import pc_stack_pkg::*;
#(
  parameter int unsigned     WIDTH       = 8,
  parameter int unsigned     STACK_DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] pc_o,
  output logic             stack_full_o,
  output logic             stack_empty_o,
  output logic             wrap_o,
  output logic             err_o
);

  localparam logic [WIDTH-1:0] AllOnes = '1;

  pc_op_t           op;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic             push, pop, full, empty;
  logic [WIDTH-1:0] stack_top;
  logic [WIDTH:0]   inc_sum;
  logic [WIDTH+1:0] jrel_sum;

  assign op       = pc_op_t'(op_i);
  assign inc_sum  = {1'b0, pc_q} + {{WIDTH{1'b0}}, 1'b1};
  // Two guard bits: bit WIDTH+1 flags a negative result, bit WIDTH an overshoot.
  assign jrel_sum = {2'b00, pc_q} + {{2{din_i[WIDTH-1]}}, din_i};

  always_comb begin
    pc_d   = pc_q;
    wrap_d = 1'b0;
    err_d  = err_q;
    push   = 1'b0;
    pop    = 1'b0;
    if (en_i) begin
      unique case (op)
        OpHold: ;
        OpInc: begin
          pc_d   = inc_sum[WIDTH-1:0];
          wrap_d = inc_sum[WIDTH];
`ifdef PC_SATURATE_EN
          if (inc_sum[WIDTH]) pc_d = AllOnes;
`endif
        end
        OpLoad: pc_d = din_i;
        OpJrel: begin
          pc_d   = jrel_sum[WIDTH-1:0];
          wrap_d = |jrel_sum[WIDTH+1:WIDTH];
`ifdef PC_SATURATE_EN
          if (wrap_d) pc_d = jrel_sum[WIDTH+1] ? '0 : AllOnes;
`endif
        end
        OpCall: begin
          if (full) begin
            err_d = 1'b1;
          end else begin
            push = 1'b1;
            pc_d = din_i;
          end
        end
        OpRet: begin
          if (empty) begin
            err_d = 1'b1;
          end else begin
            pop  = 1'b1;
            pc_d = stack_top;
          end
        end
        OpDec: begin
          pc_d   = pc_q - {{(WIDTH-1){1'b0}}, 1'b1};
          wrap_d = (pc_q == '0);
`ifdef PC_SATURATE_EN
          if (wrap_d) pc_d = '0;
`endif
        end
        OpClrErr: err_d = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_VAL;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  pc_ret_stack #(
    .WIDTH       (WIDTH),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (inc_sum[WIDTH-1:0]),
    .data_o  (stack_top),
    .full_o  (full),
    .empty_o (empty)
  );

  assign pc_o          = pc_q;
  assign stack_full_o  = full;
  assign stack_empty_o = empty;
  assign wrap_o        = wrap_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_pc_stack_counter.sv
// Scoreboard bench for pc_stack_counter against an arithmetic reference model.
module tb_pc_stack_counter;

  localparam int unsigned W     = 8;
  localparam int unsigned DEPTH = 4;
  localparam logic [W-1:0] RVAL = 8'h00;
  localparam longint Mod = longint'(1) << W;
  localparam longint Max = Mod - 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [2:0]   op;
  logic [W-1:0] din;
  logic [W-1:0] pc;
  logic         full, empty, wrap, err;

  pc_stack_counter #(
    .WIDTH       (W),
    .STACK_DEPTH (DEPTH),
    .RESET_VAL   (RVAL)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en_i          (en),
    .op_i          (op),
    .din_i         (din),
    .pc_o          (pc),
    .stack_full_o  (full),
    .stack_empty_o (empty),
    .wrap_o        (wrap),
    .err_o         (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned  cyc;
    logic [W-1:0] pc;
    logic         full, empty, wrap, err;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc_cnt = 0;
  int          checks  = 0;
  int          errors  = 0;

  longint m_pc;
  longint m_stk[$];
  bit     m_err, m_wrap;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic model_reset();
    m_pc   = longint'(RVAL);
    m_err  = 1'b0;
    m_wrap = 1'b0;
    m_stk.delete();
  endtask

  task automatic model_apply(input bit e, input int o, input longint d);
    longint t;
    m_wrap = 1'b0;
    if (!e) return;
    case (o)
      1, 3, 6: begin
        if (o == 1) t = m_pc + 1;
        else if (o == 6) t = m_pc - 1;
        else t = m_pc + ((d >= Mod / 2) ? d - Mod : d);
        if (t < 0 || t > Max) begin
          m_wrap = 1'b1;
`ifdef PC_SATURATE_EN
          m_pc = (t < 0) ? 0 : Max;
`else
          m_pc = ((t % Mod) + Mod) % Mod;
`endif
        end else begin
          m_pc = t;
        end
      end
      2: m_pc = d;
      4: begin
        if (m_stk.size() == DEPTH) m_err = 1'b1;
        else begin
          m_stk.push_back((m_pc + 1) % Mod);
          m_pc = d;
        end
      end
      5: begin
        if (m_stk.size() == 0) m_err = 1'b1;
        else m_pc = m_stk.pop_back();
      end
      7: m_err = 1'b0;
      default: ;
    endcase
  endtask

  // Drive one op after a rising edge; its expected effect is due on the next edge.
  task automatic step(input bit e, input int o, input logic [W-1:0] d);
    exp_t x;
    @(posedge clk);
    #1;
    en  = e;
    op  = 3'(o);
    din = d;
    model_apply(e, o, longint'(d));
    x.cyc   = cyc_cnt + 1;
    x.pc    = m_pc[W-1:0];
    x.full  = (m_stk.size() == DEPTH);
    x.empty = (m_stk.size() == 0);
    x.wrap  = m_wrap;
    x.err   = m_err;
    exp_q.push_back(x);
  endtask

  // Monitor: every cycle compares whatever expectations fall due.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      cyc_cnt++;
      #2;
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_cnt) begin
        x = exp_q.pop_front();
        chk("pc", 64'(pc), 64'(x.pc));
        chk("stack_full", 64'(full), 64'(x.full));
        chk("stack_empty", 64'(empty), 64'(x.empty));
        chk("wrap", 64'(wrap), 64'(x.wrap));
        chk("err", 64'(err), 64'(x.err));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    op    = 3'd0;
    din   = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    chk("reset_pc", 64'(pc), 64'(RVAL));
    chk("reset_empty", 64'(empty), 64'd1);
    chk("reset_full", 64'(full), 64'd0);
    chk("reset_wrap", 64'(wrap), 64'd0);
    chk("reset_err", 64'(err), 64'd0);
    rst_n = 1'b1;

    repeat (3) step(1, 1, '0);
    step(1, 2, 8'hFE);
    step(1, 1, '0);
    step(1, 1, '0);
    step(1, 2, 8'h10);
    step(1, 3, 8'hFC);
    step(1, 3, 8'hF0);
    step(1, 2, 8'h20);
    step(1, 4, 8'h80);
    step(1, 4, 8'h90);
    step(1, 5, '0);
    step(1, 5, '0);
    step(1, 6, '0);
    step(1, 2, 8'h00);
    step(1, 6, '0);
    for (int i = 0; i < 5; i++) step(1, 4, 8'(8'h40 + i));
    for (int i = 0; i < 5; i++) step(1, 5, '0);
    step(1, 7, '0);
    repeat (5) step(0, 1, '0);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 7) != 0), int'($urandom_range(0, 7)), W'($urandom));
    end

    // Asynchronous reset in the middle of a call sequence.
    step(1, 4, 8'hA0);
    step(1, 4, 8'hB0);
    @(posedge clk);
    #3;
    en    = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_rst_pc", 64'(pc), 64'(RVAL));
    chk("async_rst_empty", 64'(empty), 64'd1);
    chk("async_rst_err", 64'(err), 64'd0);
    exp_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(1, 5, '0);
    step(1, 1, '0);
    step(0, 1, '0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_stack_counter.md
Name: pc_stack_counter

Overview:
- Parametrised program counter for the TinyTapeout-style datapath.
- Next generation of the 8-bit load/enable counter: parametrised width and return-stack depth, up/down count, signed relative jump, and call/return with a hardware return-address stack.
- Sits between the user control inputs and the address outputs of the top-level tile.
- Exposes status flags for stack full/empty, wrap and sticky error.

Parameters:
- WIDTH, 8, bit width of the PC, the data input and each stack entry; minimum 2.
- STACK_DEPTH, 4, number of return-address entries; minimum 1.
- RESET_VAL, 0, PC value on reset; WIDTH bits wide.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  qualifies op; when low, the block holds all state.
- op  input  3  operation code; see pkg.
- din  input  WIDTH  load address, call target, or signed jump offset.
- pc  output  WIDTH  current program counter, registered.
- stack_full  output  1  high when the stack holds STACK_DEPTH entries.
- stack_empty  output  1  high when the stack holds 0 entries.
- wrap  output  1  registered one-cycle pulse when the last PC update crossed the WIDTH boundary.
- err  output  1  sticky stack overflow/underflow flag.

Behaviour:
- Reset (asynchronous, rst_n low):
  - pc=RESET_VAL, stack pointer sp=0, stack_empty=1, stack_full=0, wrap=0, err=0.
  - Stack contents are don't-care.
- Ops take effect at the clock edge where en=1. With en=0, all registers hold and wrap goes to 0.
- Op codes:
  - 0 HOLD: no change.
  - 1 INC: pc <= pc+1, modulo 2^WIDTH.
  - 2 LOAD: pc <= din.
  - 3 JREL: pc <= pc + sign-extended din (two's complement), modulo 2^WIDTH.
  - 4 CALL: push pc+1 (mod 2^WIDTH) to stack[sp]; sp <= sp+1; pc <= din.
  - 5 RET: sp <= sp-1; pc <= stack[sp-1].
  - 6 DEC: pc <= pc-1, modulo 2^WIDTH.
  - 7 CLRERR: err <= 0; pc unchanged.
- Latency: single cycle. pc reflects the op on the edge after it is presented.
- wrap is set for exactly the cycle following an INC from all-ones, a DEC from 0, or a JREL whose unbounded result falls outside [0, 2^WIDTH-1]. LOAD, CALL and RET never set wrap.
- Stack boundaries:
  - CALL when stack_full: no push, pc unchanged, err <= 1.
  - RET when stack_empty: pc unchanged, sp unchanged, err <= 1.
  - err stays at 1 until CLRERR or reset. Further ops execute normally while err=1.
- stack_full and stack_empty are combinational decodes of the registered sp, which is clog2(STACK_DEPTH+1) bits wide.
- With STACK_DEPTH=1: one CALL sets full and one RET sets empty.
- Reset asserted mid-sequence discards the stack immediately. The first op after release sees an empty stack.
- The block contains no tri-state logic. Output gating is done at the top level.

Optional Feature:
- Macro: PC_SATURATE_EN.
- Defined: INC at all-ones, DEC at 0 and out-of-range JREL clamp pc to all-ones or 0 respectively. wrap is still pulsed, marking the clamp event.
- Undefined: modulo wrap as above.
- Stack, LOAD, CALL and RET behaviour are identical in both builds.

Decomposition:
- Package pc_stack_pkg:
  - enum pc_op_t with the 8 op codes above.
  - localparam helper for the sp width.
- Sub-module pc_ret_stack: LIFO with push, pop, data in, data out, full and empty, parametrised WIDTH and STACK_DEPTH.
- Top pc_stack_counter holds the PC register, next-PC mux, wrap/saturation logic and err.

Test Plan:
- Reset/INC: release reset with RESET_VAL=0, en=1, op=INC for 3 cycles -> pc=1,2,3; stack_empty=1; err=0.
- Wrap: LOAD 8'hFE, then INC x2 -> pc=FF then 00, with wrap=1 only in the cycle pc=00. Under PC_SATURATE_EN -> pc stays FF and wrap=1.
- Relative jump: pc=8'h10, JREL din=8'hFC (-4) -> pc=8'h0C, wrap=0. Then JREL din=8'hF0 (-16) -> pc=8'hFC, wrap=1.
- Call/return nesting (DEPTH=4): pc=8'h20, CALL 8'h80, CALL 8'h90 -> pc=90. Then RET -> pc=81; RET -> pc=21, stack_empty=1.
- Overflow/underflow:
  - 4 CALLs -> stack_full=1; a 5th CALL -> pc unchanged, err=1.
  - Drain the stack with 4 RETs, then issue a 5th RET -> pc unchanged, err still 1.
  - CLRERR -> err=0.
- en/reset: en=0 with op=INC for 5 cycles -> pc constant. Assert rst_n low mid-CALL sequence -> pc=RESET_VAL and stack_empty=1 asynchronously.
